imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction-memory interface that the fetch stage reads.
- Accepts a byte stream (valid/ready) carrying a length header plus little-endian 32-bit instruction words.
- Writes each word into instruction memory at consecutive word addresses starting at 0.
- Holds the core's PC (drives the fetch PC-write-enable gate low) until loading completes, so fetch restarts from PC 0 on a fully loaded image.

Parameters:
DATA_WIDTH, 32, instruction word width (taken from shared package).
IMEM_DEPTH, 256, number of instruction words in instruction memory.
ADDR_WIDTH, $clog2(IMEM_DEPTH), word-address width (word address = PC >> 2).

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
start_i  input  1  one-cycle pulse; begins a load session.
rx_valid_i  input  1  byte-stream valid.
rx_data_i  input  8  byte-stream data.
rx_ready_o  output  1  loader accepts a byte when rx_valid_i && rx_ready_o at posedge.
imem_we_o  output  1  instruction-memory write enable (one-cycle pulse per word).
imem_addr_o  output  ADDR_WIDTH  word address of write.
imem_wdata_o  output  DATA_WIDTH  word to write.
core_hold_o  output  1  1 = core PC write disabled; AND-ed into fetch PC-write-enable.
load_done_o  output  1  level; high after a successful load until next start_i.
load_err_o  output  1  level; high after an oversize header until next start_i.

Behaviour:
- Reset (async, rst_n=0): state IDLE; rx_ready_o=0, imem_we_o=0, imem_addr_o=0, imem_wdata_o=0, core_hold_o=1, load_done_o=0, load_err_o=0; byte counter, word counter and length register cleared.
- States: IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR.
- IDLE: rx_ready_o=0, core_hold_o=1. On start_i, go to LEN_LO.
- LEN_LO / LEN_HI: rx_ready_o=1. Capture the 16-bit word count N, low byte first.
- On the LEN_HI accept:
  - N==0 -> DONE.
  - N>IMEM_DEPTH -> ERR.
  - Otherwise -> DATA, with word counter = 0.
- DATA: rx_ready_o=1.
  - Bytes are assembled little-endian: first byte is bits [7:0], fourth byte is bits [31:24].
  - On the 4th byte accept, the next cycle asserts imem_we_o=1 for exactly one cycle, with imem_addr_o = word counter and imem_wdata_o = assembled word. The word counter then increments. Write latency is 1 cycle after the final byte handshake.
  - After word N-1 is written, go to DONE. The last byte handshake is followed by the write cycle, then DONE on the following cycle.
- Back-to-back bytes (rx_valid_i held high) are accepted every cycle with no bubbles. A gap in rx_valid_i simply pauses the stream.
- DONE: load_done_o=1, core_hold_o=0, rx_ready_o=0.
- ERR: load_err_o=1, core_hold_o=1, rx_ready_o=0. No memory writes occur.
- start_i in DONE or ERR: clear the done/err flags, set core_hold_o=1, go to LEN_LO (reload).
- start_i in LEN_LO, LEN_HI or DATA: ignored.
- imem_addr_o holds its last value when imem_we_o=0. The word counter never exceeds IMEM_DEPTH-1 at a write, because this is guaranteed by the header check.
- Reset mid-load: immediate return to IDLE. The partial image is left in memory and core_hold_o=1.

Decomposition:
- Shared package (defines): DATA_WIDTH, IMEM_DEPTH, and typedef enum loader_state_e {IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR}.
- One natural sub-module: byte_packer (byte-to-word little-endian assembler).
  - Inputs: byte + accept strobe.
  - Outputs: 32-bit word + word_valid pulse.
  - Has a clear input that the FSM drives on start.

Test Plan:
1. Reset, no start -> core_hold_o=1, rx_ready_o=0, imem_we_o never asserted over 20 cycles.
2. start_i, bytes 02 00 | 13 05 10 00 | 93 05 20 00 -> writes addr 0 = 0x00100513, then addr 1 = 0x00200593, each one cycle after its 4th byte. Then load_done_o=1 and core_hold_o=0.
3. Same image with rx_valid_i toggling every other cycle -> identical writes and data. No write occurs before the 4th byte of each word.
4. start_i, header 00 00 -> DONE two cycles after the start pulse, zero writes.
5. start_i, header 01 01 (N=257 > 256) -> load_err_o=1, core_hold_o=1, rx_ready_o=0, zero writes. A following start_i plus valid 1-word image -> load_done_o=1, err cleared.
6. rst_n pulled low after 6 data bytes -> all outputs at reset values immediately. A new start_i plus a 1-word image writes addr 0 correctly.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   DATA_WIDTH     : instruction word width
//   IMEM_DEPTH     : number of instruction words in instruction memory
//   LEN_WIDTH      : width of the word-count header carried in the byte stream
//   loader_state_e : loader session states
package imem_loader_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int IMEM_DEPTH = 256;
   localparam int LEN_WIDTH  = 16;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      DONE,
      ERR
   } loader_state_e;

endpackage

// File: rtl/imem_loader_packer.sv
// byte_packer: assembles a stream of accepted bytes into little-endian words.
//   clk, rst_n    : clock, asynchronous active-low reset
//   clear_i       : restart assembly at byte lane 0
//   accept_i      : byte_i is taken this cycle
//   byte_i        : incoming byte
//   word_o        : assembled word, complete when word_valid_o is high
//   word_valid_o  : same-cycle pulse on the accept that completes a word
module byte_packer #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear_i,
   input  logic                  accept_i,
   input  logic [7:0]            byte_i,
   output logic [DATA_WIDTH-1:0] word_o,
   output logic                  word_valid_o
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [DATA_WIDTH-1:0] asm_q, asm_d;

   // The completed word is presented combinationally (stored lanes plus the
   // byte arriving now) so the parent can register the memory write on the
   // same edge that accepts the final byte.
   always_comb begin
      word_o                      = asm_q;
      word_o[int'(idx_q)*8 +: 8]  = byte_i;
      word_valid_o                = accept_i && (idx_q == LAST_IDX);
      asm_d                       = asm_q;
      idx_d                       = idx_q;
      if (clear_i) begin
         idx_d = '0;
      end else if (accept_i) begin
         asm_d = word_o;
         idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= '0;
         asm_q <= '0;
      end else begin
         idx_q <= idx_d;
         asm_q <= asm_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory read by the fetch stage.
// Receives a byte stream (16-bit word count, low byte first, followed by
// little-endian instruction words), writes the words to consecutive word
// addresses from 0, and holds the core PC until the image is fully loaded.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start_i        : one-cycle pulse, begins (or restarts) a load session
//   rx_valid_i     : byte-stream valid
//   rx_data_i      : byte-stream data
//   rx_ready_o     : byte accepted when rx_valid_i && rx_ready_o at posedge
//   imem_we_o      : one-cycle write pulse per word
//   imem_addr_o    : word address of the write (holds when idle)
//   imem_wdata_o   : word to write
//   core_hold_o    : 1 = core PC write disabled
//   load_done_o    : image loaded successfully
//   load_err_o     : header word count exceeded IMEM_DEPTH
module imem_loader #(
   parameter int DATA_WIDTH = imem_loader_pkg::DATA_WIDTH,
   parameter int IMEM_DEPTH = imem_loader_pkg::IMEM_DEPTH,
   parameter int ADDR_WIDTH = $clog2(IMEM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic                  rx_valid_i,
   input  logic [7:0]            rx_data_i,
   output logic                  rx_ready_o,
   output logic                  imem_we_o,
   output logic [ADDR_WIDTH-1:0] imem_addr_o,
   output logic [DATA_WIDTH-1:0] imem_wdata_o,
   output logic                  core_hold_o,
   output logic                  load_done_o,
   output logic                  load_err_o
);

   import imem_loader_pkg::*;

   localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(IMEM_DEPTH);

   loader_state_e         state_q, state_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [LEN_WIDTH-1:0]  word_cnt_q, word_cnt_d;
   logic                  imem_we_q, imem_we_d;
   logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
   logic [DATA_WIDTH-1:0] imem_wdata_q, imem_wdata_d;

   logic                  pack_clear;
   logic                  pack_accept;
   logic                  pack_valid;
   logic [DATA_WIDTH-1:0] pack_word;
   logic                  last_write;
   logic [LEN_WIDTH-1:0]  len_hdr;

   // Write cycle of the final word: the stream is closed during it so no
   // byte of a following transfer is swallowed before DONE.
   assign last_write  = imem_we_q && (word_cnt_q == len_q - LEN_WIDTH'(1));
   assign len_hdr     = {rx_data_i, len_q[7:0]};
   assign pack_accept = rx_valid_i && rx_ready_o && (state_q == DATA);

   byte_packer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_packer (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear_i      (pack_clear),
      .accept_i     (pack_accept),
      .byte_i       (rx_data_i),
      .word_o       (pack_word),
      .word_valid_o (pack_valid)
   );

   // Handshake and status outputs depend only on registered state.
   always_comb begin
      rx_ready_o  = 1'b0;
      core_hold_o = 1'b1;
      load_done_o = 1'b0;
      load_err_o  = 1'b0;
      case (state_q)
         LEN_LO, LEN_HI: rx_ready_o = 1'b1;
         DATA:           rx_ready_o = !last_write;
         DONE: begin
            core_hold_o = 1'b0;
            load_done_o = 1'b1;
         end
         ERR:            load_err_o = 1'b1;
         default:        ;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      word_cnt_d   = word_cnt_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      pack_clear   = 1'b0;

      case (state_q)
         IDLE, DONE, ERR: begin
            if (start_i) begin
               state_d    = LEN_LO;
               pack_clear = 1'b1;
            end
         end

         LEN_LO: begin
            if (rx_valid_i) begin
               len_d   = {8'h00, rx_data_i};
               state_d = LEN_HI;
            end
         end

         LEN_HI: begin
            if (rx_valid_i) begin
               len_d      = len_hdr;
               word_cnt_d = '0;
               if (len_hdr == '0) begin
                  state_d = DONE;
               end else if (len_hdr > LEN_MAX) begin
                  state_d = ERR;
               end else begin
                  state_d = DATA;
               end
            end
         end

         DATA: begin
            if (pack_valid) begin
               imem_we_d    = 1'b1;
               imem_addr_d  = word_cnt_q[ADDR_WIDTH-1:0];
               imem_wdata_d = pack_word;
            end
            // Counter advances in the write cycle; the next word's final
            // byte is at least three cycles away, so the address is fresh.
            if (imem_we_q) begin
               word_cnt_d = word_cnt_q + LEN_WIDTH'(1);
            end
            if (last_write) begin
               state_d = DONE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         len_q        <= '0;
         word_cnt_q   <= '0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         word_cnt_q   <= word_cnt_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
      end
   end

   assign imem_we_o    = imem_we_q;
   assign imem_addr_o  = imem_addr_q;
   assign imem_wdata_o = imem_wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: randomized and directed load sessions; a
// reference model derives the expected memory writes (address, data, cycle)
// from the header and image words; a monitor checks every write against
// the scoreboard queue.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_i;
   logic        rx_valid_i;
   logic [7:0]  rx_data_i;
   logic        rx_ready_o;
   logic        imem_we_o;
   logic [7:0]  imem_addr_o;
   logic [31:0] imem_wdata_o;
   logic        core_hold_o;
   logic        load_done_o;
   logic        load_err_o;

   imem_loader #(
      .DATA_WIDTH (32),
      .IMEM_DEPTH (256),
      .ADDR_WIDTH (8)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start_i),
      .rx_valid_i   (rx_valid_i),
      .rx_data_i    (rx_data_i),
      .rx_ready_o   (rx_ready_o),
      .imem_we_o    (imem_we_o),
      .imem_addr_o  (imem_addr_o),
      .imem_wdata_o (imem_wdata_o),
      .core_hold_o  (core_hold_o),
      .load_done_o  (load_done_o),
      .load_err_o   (load_err_o)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
      int unsigned cyc;
   } wr_t;

   wr_t         sb[$];
   logic [31:0] img[$];
   int unsigned n_pass  = 0;
   int unsigned n_total = 0;
   bit          tog     = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: every write must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && imem_we_o !== 1'b0) begin
         if (sb.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h we %b, required no write (cycle %0d)",
                     imem_addr_o, imem_wdata_o, imem_we_o, cyc);
         end else begin
            wr_t e;
            e = sb.pop_front();
            check("wr_addr", {24'h0, imem_addr_o}, {24'h0, e.addr});
            check("wr_data", imem_wdata_o, e.data);
            check("wr_cycle", cyc, e.cyc);
         end
      end
   end

   // mode: 0 = back-to-back, 1 = valid toggles every other cycle, 2 = random gaps.
   // Called at a negedge; returns at the negedge after the handshake edge.
   task automatic send_byte(input logic [7:0] b, input int mode, output int unsigned hs);
      int unsigned waited;
      waited = 0;
      hs     = 0;
      forever begin
         bit gap;
         tog = ~tog;
         gap = (mode == 1) ? tog : (mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
         if (gap) begin
            rx_valid_i = 1'b0;
            rx_data_i  = 8'($urandom);
         end else begin
            rx_valid_i = 1'b1;
            rx_data_i  = b;
         end
         if (rx_valid_i && rx_ready_o) begin
            hs = cyc + 1;
            @(negedge clk);
            rx_valid_i = 1'b0;
            return;
         end
         @(negedge clk);
         waited++;
         if (waited > 100) begin
            n_total++;
            $display("FAIL byte_accept_timeout: got no handshake in 100 cycles, required acceptance (cycle %0d)", cyc);
            rx_valid_i = 1'b0;
            return;
         end
      end
   endtask

   task automatic pulse_start(output int unsigned st);
      start_i = 1'b1;
      st      = cyc + 1;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   // One session: header n, then n words from img when the header is legal.
   task automatic load(input int unsigned n, input int mode, input bit poke_start);
      int unsigned st, hs, seen, waited;
      bit          exp_done;
      logic [31:0] nv;
      nv       = n;
      exp_done = (n <= 256);
      pulse_start(st);
      send_byte(nv[7:0], mode, hs);
      send_byte(nv[15:8], mode, hs);
      if (n >= 1 && n <= 256) begin
         check("hold_during_load", {31'h0, core_hold_o}, 32'h1);
         for (int unsigned w = 0; w < n; w++) begin
            logic [31:0] word;
            word = img[w];
            for (int unsigned b = 0; b < 4; b++) begin
               if (poke_start && w == 0 && b == 0) start_i = 1'b1;
               send_byte(8'((word >> (8 * b)) & 32'hff), mode, hs);
               start_i = 1'b0;
               if (b == 3) sb.push_back('{addr: 8'(w), data: word, cyc: hs});
            end
         end
      end
      waited = 0;
      while (load_done_o !== 1'b1 && load_err_o !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      seen = cyc;
      if (waited >= 20) begin
         n_total++;
         $display("FAIL session_end_timeout: got no done/err in 20 cycles, required end of session n=%0d", n);
      end
      if (n == 0 && mode == 0) check("done_latency", seen - st, 2);
      check("load_done", {31'h0, load_done_o}, {31'h0, exp_done});
      check("load_err", {31'h0, load_err_o}, {31'h0, !exp_done});
      check("core_hold", {31'h0, core_hold_o}, {31'h0, !exp_done});
      check("rx_ready_end", {31'h0, rx_ready_o}, 32'h0);
      check("sb_drained", sb.size(), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rx_ready"}, {31'h0, rx_ready_o}, 32'h0);
      check({tag, "_we"}, {31'h0, imem_we_o}, 32'h0);
      check({tag, "_addr"}, {24'h0, imem_addr_o}, 32'h0);
      check({tag, "_wdata"}, imem_wdata_o, 32'h0);
      check({tag, "_hold"}, {31'h0, core_hold_o}, 32'h1);
      check({tag, "_done"}, {31'h0, load_done_o}, 32'h0);
      check({tag, "_err"}, {31'h0, load_err_o}, 32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      int unsigned hs;
      rst_n      = 1'b0;
      start_i    = 1'b0;
      rx_valid_i = 1'b0;
      rx_data_i  = 8'h00;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;

      // Idle after reset: held, not ready, never writes.
      for (int i = 0; i < 20; i++) begin
         rx_valid_i = 1'b1;
         rx_data_i  = 8'($urandom);
         @(negedge clk);
         check("idle_hold", {31'h0, core_hold_o}, 32'h1);
         check("idle_ready", {31'h0, rx_ready_o}, 32'h0);
      end
      rx_valid_i = 1'b0;

      // Two-word reference image, back-to-back then toggling valid.
      img = {};
      img.push_back(32'h00100513);
      img.push_back(32'h00200593);
      load(2, 0, 1'b0);
      load(2, 1, 1'b1);

      // Empty image and oversize header followed by a good reload.
      load(0, 0, 1'b0);
      load(257, 0, 1'b0);
      img = {};
      img.push_back(32'hdeadbeef);
      load(1, 0, 1'b0);

      // Random images and random oversize headers.
      for (int s = 0; s < 6; s++) begin
         int unsigned n;
         n   = $urandom_range(1, 6);
         img = {};
         for (int unsigned w = 0; w < n; w++) img.push_back($urandom);
         load(n, 2, s == 2);
      end
      load($urandom_range(258, 65535), 2, 1'b0);
      img = {};
      img.push_back($urandom);
      load(1, 2, 1'b0);

      // Reset part-way through the second word.
      begin
         int unsigned st;
         img = {};
         img.push_back(32'h11223344);
         img.push_back(32'h55667788);
         pulse_start(st);
         send_byte(8'h02, 0, hs);
         send_byte(8'h00, 0, hs);
         for (int unsigned k = 0; k < 6; k++) begin
            send_byte(8'((img[k / 4] >> (8 * (k % 4))) & 32'hff), 0, hs);
            if (k == 3) sb.push_back('{addr: 8'h00, data: img[0], cyc: hs});
         end
         rst_n = 1'b0;
         #1;
         check_reset_outputs("midreset");
         repeat (2) @(negedge clk);
         rst_n = 1'b1;
         img = {};
         img.push_back(32'hcafef00d);
         load(1, 0, 1'b0);
      end

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
